// File: rtl/register_pair_port_if.sv
// rtl/register_pair_port_if.sv - request/response and RAM port bundle for the register pair sequencer
interface register_pair_port_if #(
    parameter int LEVEL_BITS = 4,
    parameter int INDEX_BITS = 4
);
    localparam int AW = LEVEL_BITS + INDEX_BITS;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_word;
    logic [LEVEL_BITS-1:0] req_level;
    logic [INDEX_BITS-1:0] req_index;
    logic [15:0]           req_wdata;
    logic                  rsp_valid;
    logic [15:0]           rsp_rdata;
    logic [AW-1:0]         ram_address;
    logic                  ram_write_en;
    logic [7:0]            ram_data_in;
    logic [7:0]            ram_data_out;

    modport master (
        output req_valid, req_write, req_word, req_level, req_index, req_wdata, ram_data_out,
        input  req_ready, rsp_valid, rsp_rdata, ram_address, ram_write_en, ram_data_in
    );

    modport slave (
        input  req_valid, req_write, req_word, req_level, req_index, req_wdata, ram_data_out,
        output req_ready, rsp_valid, rsp_rdata, ram_address, ram_write_en, ram_data_in
    );
endinterface

// File: rtl/register_pair_port.sv
// rtl/register_pair_port.sv - sequences byte/word register requests onto a 256x8 synchronous RAM
module register_pair_port #(
    parameter int LEVEL_BITS = 4,
    parameter int INDEX_BITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    register_pair_port_if.slave  bus
);
    localparam int AW = LEVEL_BITS + INDEX_BITS;

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPTURE, RESP} state_t;

    state_t        state_q, state_d;
    logic          write_q, write_d;
    logic          word_q, word_d;
    logic [AW-1:0] base_q, base_d;
    logic [15:0]   wdata_q, wdata_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   rsp_q, rsp_d;
    logic [AW-1:0] last_addr_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            word_q      <= 1'b0;
            base_q      <= '0;
            wdata_q     <= 16'h0000;
            hi_q        <= 8'h00;
            rsp_q       <= 16'h0000;
            last_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            word_q      <= word_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            hi_q        <= hi_d;
            rsp_q       <= rsp_d;
            last_addr_q <= bus.ram_address;
        end
    end

    always_comb begin
        state_d          = state_q;
        write_d          = write_q;
        word_d           = word_q;
        base_d           = base_q;
        wdata_d          = wdata_q;
        hi_d             = hi_q;
        rsp_d            = rsp_q;
        bus.req_ready    = 1'b0;
        bus.rsp_valid    = 1'b0;
        bus.ram_address  = last_addr_q;
        bus.ram_write_en = 1'b0;
        bus.ram_data_in  = 8'h00;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    word_d  = bus.req_word;
                    wdata_d = bus.req_wdata;
                    base_d  = bus.req_word ? {bus.req_level, bus.req_index[INDEX_BITS-1:1], 1'b0}
                                           : {bus.req_level, bus.req_index};
                    state_d = ISSUE0;
                end
            end
            ISSUE0: begin
                bus.ram_address  = base_q;
                bus.ram_data_in  = word_q ? wdata_q[15:8] : wdata_q[7:0];
                bus.ram_write_en = write_q;
                if (word_q)
                    state_d = ISSUE1;
                else
                    state_d = write_q ? RESP : CAPTURE;
            end
            ISSUE1: begin
                bus.ram_address  = {base_q[AW-1:1], 1'b1};
                bus.ram_data_in  = wdata_q[7:0];
                bus.ram_write_en = write_q;
                // RAM now returns the even (high) byte addressed in ISSUE0
                if (!write_q)
                    hi_d = bus.ram_data_out;
                state_d = write_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                // Result is committed here so it is already valid alongside the RESP strobe
                rsp_d   = {word_q ? hi_q : 8'h00, bus.ram_data_out};
                state_d = RESP;
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.rsp_rdata = rsp_q;
endmodule

// File: tb/tb_register_pair_port.sv
// tb/tb_register_pair_port.sv - randomized and directed check of register_pair_port against a memory model
module tb_register_pair_port;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    register_pair_port_if bus ();
    register_pair_port dut (.clock(clock), .reset(reset), .bus(bus));

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    logic [7:0] ram_dout;
    bit ram_inited = 1'b0;
    assign bus.ram_data_out = ram_dout;

    always @(posedge clock) begin
        if (!ram_inited) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
            ram_inited <= 1'b1;
            ram_dout   <= 8'hFF;
        end else begin
            if (bus.ram_write_en) mem[bus.ram_address] <= bus.ram_data_in;
            ram_dout <= mem[bus.ram_address];
        end
    end

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_rsp = 16'h0000;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        bus.req_write = 1'($urandom);
        bus.req_word  = 1'($urandom);
        bus.req_level = 4'($urandom);
        bus.req_index = 4'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    task automatic do_req(input bit w, input bit wd, input logic [3:0] lv, input logic [3:0] ix,
                          input logic [15:0] d);
        int n;
        int lat;
        int exp_lat;
        int a;
        bus.req_write = w;
        bus.req_word  = wd;
        bus.req_level = lv;
        bus.req_index = ix;
        bus.req_wdata = d;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_idle", 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        scramble();

        a = wd ? (int'(lv) * 16 + int'(ix & 4'hE)) : (int'(lv) * 16 + int'(ix));
        exp_lat = 2 + (w ? 0 : 1) + (wd ? 1 : 0);
        if (w) begin
            if (wd) begin
                ref_mem[a]     = d[15:8];
                ref_mem[a + 1] = d[7:0];
            end else begin
                ref_mem[a] = d[7:0];
            end
        end else begin
            exp_rsp = wd ? {ref_mem[a], ref_mem[a + 1]} : {8'h00, ref_mem[a]};
        end

        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            chk("busy_ready", 32'(bus.req_ready), 32'd0);
            step();
            lat++;
        end
        chk("latency", lat, exp_lat);
        chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rsp));
        step();
        chk("strobe_low", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'hFF;
        bus.req_valid = 1'b0;
        scramble();
        step();
        step();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0000);
        chk("rst_we", 32'(bus.ram_write_en), 32'd0);
        chk("rst_addr", 32'(bus.ram_address), 32'h00);
        chk("rst_din", 32'(bus.ram_data_in), 32'h00);
        reset = 1'b0;
        step();

        do_req(1'b0, 1'b1, 4'h0, 4'h0, 16'h0000);
        do_req(1'b1, 1'b1, 4'h3, 4'h5, 16'h1234);
        chk("mem_34", 32'(mem[8'h34]), 32'h12);
        chk("mem_35", 32'(mem[8'h35]), 32'h34);
        do_req(1'b0, 1'b1, 4'h3, 4'h4, 16'h0000);
        do_req(1'b1, 1'b0, 4'hF, 4'hF, 16'hBEA5);
        chk("mem_ff", 32'(mem[8'hFF]), 32'hA5);
        chk("mem_fe", 32'(mem[8'hFE]), 32'hFF);
        do_req(1'b0, 1'b0, 4'hF, 4'hF, 16'h0000);
        do_req(1'b1, 1'b1, 4'h5, 4'h0, 16'h5A5A);

        // held request while busy: decoy fields must never be taken
        bus.req_write = 1'b1; bus.req_word = 1'b1; bus.req_level = 4'h2;
        bus.req_index = 4'h6; bus.req_wdata = 16'hA1B2; bus.req_valid = 1'b1;
        step();
        bus.req_write = 1'b1; bus.req_word = 1'b0; bus.req_level = 4'h0;
        bus.req_index = 4'h0; bus.req_wdata = 16'h0077;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            chk("held_busy_ready", 32'(bus.req_ready), 32'd0);
            step();
            lat++;
        end
        chk("held_latency", lat, 3);
        chk("held_resp_ready", 32'(bus.req_ready), 32'd0);
        step();
        chk("held_idle_ready", 32'(bus.req_ready), 32'd1);
        ref_mem[8'h26] = 8'hA1;
        ref_mem[8'h27] = 8'hB2;
        bus.req_valid = 1'b0;
        do_req(1'b0, 1'b0, 4'h2, 4'h7, 16'h0000);
        chk("decoy_mem_00", 32'(mem[8'h00]), 32'hFF);

        // reset during ISSUE1 of a word write
        bus.req_write = 1'b1; bus.req_word = 1'b1; bus.req_level = 4'h1;
        bus.req_index = 4'h2; bus.req_wdata = 16'hCAFE; bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        step();
        chk("issue1_we", 32'(bus.ram_write_en), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_we", 32'(bus.ram_write_en), 32'd0);
        chk("abort_ready", 32'(bus.req_ready), 32'd1);
        chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("abort_mem_12", 32'(mem[8'h12]), 32'hCA);
        chk("abort_mem_13", 32'(mem[8'h13]), 32'hFF);
        ref_mem[8'h12] = 8'hCA;
        exp_rsp = 16'h0000;
        chk("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'h0000);

        for (int k = 0; k < 60; k++) begin
            do_req(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 16'($urandom));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end

        for (int i = 0; i < 256; i++) chk($sformatf("mem_%02h", i), 32'(mem[i]), 32'(ref_mem[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/register_pair_port.md
Name: register_pair_port

Overview:
- Sequencer between the CPU datapath and the 256x8 synchronous register RAM.
- Turns byte or 16-bit register-pair read/write requests into RAM cycles. RAM address is {level[3:0], index[3:0]}.
- Absorbs the RAM's one-cycle read latency and returns assembled data with a single-cycle response strobe.
- Byte order is big-endian: the high byte sits at the even address, the low byte at the odd address.

Parameters:
- LEVEL_BITS, 4, width of the interrupt-level field; upper address bits.
- INDEX_BITS, 4, width of the byte-index field; lower address bits. LEVEL_BITS+INDEX_BITS = 8 is fixed for this design.

Ports:
- clock  in  1  single system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_word  in  1  1 = 16-bit pair, 0 = single byte.
- req_level  in  4  register level.
- req_index  in  4  byte index. Bit 0 is ignored when req_word=1.
- req_wdata  in  16  write data. Byte writes use [7:0].
- rsp_valid  out  1  one-cycle completion strobe, for reads and writes.
- rsp_rdata  out  16  read result. Byte reads are zero-extended.
- ram_address  out  8  RAM address.
- ram_write_en  out  1  RAM write enable.
- ram_data_in  out  8  RAM write data.
- ram_data_out  in  8  RAM read data, valid one cycle after its address was presented.

Behaviour:
- Reset values (asynchronous, immediate):
  - state = IDLE; req_ready = 1.
  - rsp_valid = 0; rsp_rdata = 16'h0000.
  - ram_write_en = 0; ram_address = 8'h00; ram_data_in = 8'h00.
- Handshake:
  - Request accepted on a rising edge when req_valid && req_ready.
  - req_ready = 1 only in IDLE.
  - All request fields are latched at accept; later input changes are ignored.
  - No response backpressure: rsp_valid is high for exactly one cycle.
- Base address: {req_level, req_index} for bytes; {req_level, req_index[3:1], 1'b0} for words. A word never crosses a level boundary.
- RAM outputs are decoded combinationally from state and latched registers. ram_write_en is high only in ISSUE0 and ISSUE1, and only for writes.
- States:
  - IDLE: ram_write_en = 0; ram_address holds the last value. On accept -> ISSUE0.
  - ISSUE0: ram_address = base. ram_data_in = wdata[15:8] for a word, wdata[7:0] for a byte.
    - Word -> ISSUE1.
    - Byte read -> CAPTURE.
    - Byte write -> RESP.
  - ISSUE1: ram_address = base | 1; ram_data_in = wdata[7:0].
    - Read: latch ram_data_out into rdata[15:8] (high byte from ISSUE0).
    - Read -> CAPTURE; write -> RESP.
  - CAPTURE: latch ram_data_out into rdata[7:0]. For a byte read, rdata[15:8] = 0. -> RESP.
  - RESP: rsp_valid = 1; rsp_rdata is updated on reads and unchanged on writes. -> IDLE.
- Latency, accept edge to rsp_valid high:
  - byte write: 2 cycles.
  - byte read: 3 cycles.
  - word write: 3 cycles.
  - word read: 4 cycles.
  - Back-to-back throughput = latency + 1 (one IDLE cycle between requests).
- No RAM read and write to the same address share a cycle, so read-during-write ordering never matters.
- Reset mid-operation: ram_write_en drops immediately and the FSM returns to IDLE.
  - A word write interrupted after ISSUE0 leaves only the high byte written. This is accepted and not repaired.
  - No rsp_valid is produced for the aborted request.
- rsp_rdata is stable from RESP until the next read completes.

Test Plan:
- Release reset with RAM at power-up 8'hFF; word read level 0, index 0 -> addresses 0x00 then 0x01; rsp_valid 4 cycles after accept; rsp_rdata = 16'hFFFF.
- Word write level 3, index 5, wdata 16'h1234 -> RAM[0x34] = 8'h12, RAM[0x35] = 8'h34; rsp_valid 3 cycles after accept. Then word read level 3, index 4 -> 16'h1234.
- Byte write level 4'hF, index 4'hF, wdata 16'hBEA5 -> only RAM[0xFF] = 8'hA5, and RAM[0xFE] is unchanged. Then byte read -> rsp_rdata = 16'h00A5 after 3 cycles.
- Hold req_valid with a second request while busy -> req_ready = 0 until IDLE. The second request is accepted the cycle after rsp_valid, and its fields are not sampled earlier.
- Assert reset during ISSUE1 of a word write of 16'hCAFE at level 1, index 2 ->
  - ram_write_en = 0 immediately; rsp_valid never fires; req_ready = 1.
  - RAM[0x12] = 8'hCA and RAM[0x13] still 8'hFF.
- Write then read after a write: rsp_rdata retains the previous read value (16'h00A5) through the write's RESP.
